// File: rtl/vga_pkg.sv
// Shared VGA constants and types: colour width, default region colours and the
// configuration FSM encoding used by the text colour controller.
package vga_pkg;

    localparam int RGB_W = 3;

    localparam logic [RGB_W-1:0] BLACK      = 3'b000;
    localparam logic [RGB_W-1:0] DEF_COLOR0 = 3'b010;
    localparam logic [RGB_W-1:0] DEF_COLOR1 = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COMMIT  = 2'd2
    } cfg_state_t;

    typedef struct packed {
        logic             sel;
        logic [RGB_W-1:0] color;
        logic             blink;
    } cfg_shadow_t;

endpackage

// File: rtl/vga_blink_timer.sv
// Frame counter that toggles blink_phase every BLINK_FRAMES vertical retraces.
module vga_blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync_tick,
    output logic blink_phase
);

    localparam int CNT_W = $clog2(BLINK_FRAMES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_phase;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (vsync_tick) begin
            if (r_frame_cnt == CNT_LAST) begin
                r_frame_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign blink_phase = r_phase;

endmodule

// File: rtl/vga_text_color_ctrl.sv
// Per-pixel text colour / mask scheduler with frame-synchronous configuration
// commit and per-region blink.
module vga_text_color_ctrl
    import vga_pkg::*;
#(
    parameter int               BLINK_FRAMES   = 30,
    parameter logic [RGB_W-1:0] DEFAULT_COLOR0 = DEF_COLOR0,
    parameter logic [RGB_W-1:0] DEFAULT_COLOR1 = DEF_COLOR1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync_tick,
    input  logic             video_on,
    input  logic [1:0]       txt_on,
    input  logic             cfg_valid,
    input  logic             cfg_sel,
    input  logic [RGB_W-1:0] cfg_color,
    input  logic             cfg_blink,
    output logic             cfg_ready,
    output logic [RGB_W-1:0] next_rgb,
    output logic [1:0]       txt_mask,
    output logic             video_on_q
);

    cfg_state_t       r_state;
    cfg_state_t       w_state_nxt;
    cfg_shadow_t      r_shadow;
    logic [RGB_W-1:0] r_color0;
    logic [RGB_W-1:0] r_color1;
    logic [1:0]       r_blink_en;
    logic             w_blink_phase;
    logic             w_accept;
    logic             w_commit;
    logic [1:0]       w_eff;
    logic [RGB_W-1:0] w_rgb;
    logic [RGB_W-1:0] r_next_rgb;
    logic [1:0]       r_txt_mask;
    logic             r_video_on_q;

    vga_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink_timer (
        .clk         (clk),
        .reset       (reset),
        .vsync_tick  (vsync_tick),
        .blink_phase (w_blink_phase)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = 1'b0;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                w_accept  = cfg_valid;
                if (cfg_valid) w_state_nxt = ST_PENDING;
            end
            // A tick seen in IDLE never commits; only PENDING watches vsync.
            ST_PENDING: if (vsync_tick) w_state_nxt = ST_COMMIT;
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow   <= '0;
            r_color0   <= DEFAULT_COLOR0;
            r_color1   <= DEFAULT_COLOR1;
            r_blink_en <= 2'b00;
        end else begin
            if (w_accept) r_shadow <= '{sel: cfg_sel, color: cfg_color, blink: cfg_blink};
            if (w_commit) begin
                if (r_shadow.sel) r_color1 <= r_shadow.color;
                else              r_color0 <= r_shadow.color;
                r_blink_en[r_shadow.sel] <= r_shadow.blink;
            end
        end
    end

    assign w_eff = txt_on & ~(r_blink_en & {2{w_blink_phase}});

    always_comb begin
        w_rgb = BLACK;
        if (w_eff[1])      w_rgb = r_color1;
        else if (w_eff[0]) w_rgb = r_color0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_next_rgb   <= BLACK;
            r_txt_mask   <= 2'b00;
            r_video_on_q <= 1'b0;
        end else begin
            r_next_rgb   <= w_rgb;
            r_txt_mask   <= w_eff;
            r_video_on_q <= video_on;
        end
    end

    assign next_rgb   = r_next_rgb;
    assign txt_mask   = r_txt_mask;
    assign video_on_q = r_video_on_q;

endmodule

// File: tb/tb_vga_text_color_ctrl.sv
// Directed bench for vga_text_color_ctrl with BLINK_FRAMES = 2; inputs change
// and outputs are sampled on the falling edge.
module tb_vga_text_color_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync_tick;
    logic       video_on;
    logic [1:0] txt_on;
    logic       cfg_valid;
    logic       cfg_sel;
    logic [2:0] cfg_color;
    logic       cfg_blink;
    logic       cfg_ready;
    logic [2:0] next_rgb;
    logic [1:0] txt_mask;
    logic       video_on_q;

    int total = 0;
    int bad   = 0;

    vga_text_color_ctrl #(
        .BLINK_FRAMES   (2),
        .DEFAULT_COLOR0 (3'b010),
        .DEFAULT_COLOR1 (3'b100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vsync_tick (vsync_tick),
        .video_on   (video_on),
        .txt_on     (txt_on),
        .cfg_valid  (cfg_valid),
        .cfg_sel    (cfg_sel),
        .cfg_color  (cfg_color),
        .cfg_blink  (cfg_blink),
        .cfg_ready  (cfg_ready),
        .next_rgb   (next_rgb),
        .txt_mask   (txt_mask),
        .video_on_q (video_on_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic frame_tick();
        vsync_tick = 1'b1;
        cyc();
        vsync_tick = 1'b0;
        cyc();
    endtask

    task automatic pix(input string tag, input int rgb, input int mask);
        check({tag, "_rgb"}, 32'(next_rgb), rgb);
        check({tag, "_mask"}, 32'(txt_mask), mask);
    endtask

    initial begin
        reset = 1'b1; vsync_tick = 1'b0; video_on = 1'b0; txt_on = 2'b00;
        cfg_valid = 1'b0; cfg_sel = 1'b0; cfg_color = 3'b000; cfg_blink = 1'b0;
        @(negedge clk);
        cyc(2);
        pix("reset", 0, 0);
        check("reset_von", 32'(video_on_q), 0);
        check("reset_ready", 32'(cfg_ready), 1);

        // Pixel path basics and priority.
        reset = 1'b0; txt_on = 2'b01; video_on = 1'b1;
        cyc();
        pix("r0", 3'b010, 2'b01);
        check("r0_von", 32'(video_on_q), 1);
        txt_on = 2'b11; cyc(); pix("prio", 3'b100, 2'b11);
        txt_on = 2'b00; cyc(); pix("none", 3'b000, 2'b00);
        txt_on = 2'b01; video_on = 1'b0; cyc(); pix("blank", 3'b010, 2'b01);
        check("blank_von", 32'(video_on_q), 0);
        video_on = 1'b1;

        // Mid-frame config of region 0: held until the next vsync, then committed.
        cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_color = 3'b111; cfg_blink = 1'b0;
        cyc();
        cfg_valid = 1'b0;
        check("pend_ready", 32'(cfg_ready), 0);
        cyc(3);
        pix("pend_hold", 3'b010, 2'b01);
        vsync_tick = 1'b1; cyc(); vsync_tick = 1'b0;   // frame count 0->1
        check("commit_ready", 32'(cfg_ready), 0);
        check("commit_rgb", 32'(next_rgb), 3'b010);
        cyc();
        check("post_commit_ready", 32'(cfg_ready), 1);
        check("post_commit_rgb", 32'(next_rgb), 3'b010);
        cyc();
        check("new_color0", 32'(next_rgb), 3'b111);

        // Accept coincident with vsync: that tick must not commit (count 1->0, phase 1).
        cfg_valid = 1'b1; cfg_sel = 1'b1; cfg_color = 3'b011; cfg_blink = 1'b1;
        vsync_tick = 1'b1;
        cyc();
        cfg_valid = 1'b0; vsync_tick = 1'b0; txt_on = 2'b11;
        cyc(3);
        check("same_tick_ready", 32'(cfg_ready), 0);
        pix("same_tick_old", 3'b100, 2'b11);
        vsync_tick = 1'b1; cyc(); vsync_tick = 1'b0;   // count 0->1, PENDING->COMMIT
        cyc(2);
        check("second_tick_ready", 32'(cfg_ready), 1);
        pix("blink_off_phase1", 3'b111, 2'b01);

        // Blink cadence, BLINK_FRAMES = 2: phase flips every second tick.
        frame_tick();                                  // count 1->0, phase 0
        pix("blink_phase0", 3'b011, 2'b11);
        frame_tick();                                  // count 0->1
        pix("blink_mid", 3'b011, 2'b11);
        frame_tick();                                  // count 1->0, phase 1
        pix("blink_hidden", 3'b111, 2'b01);
        frame_tick(); frame_tick();                    // phase 0 again
        pix("blink_back", 3'b011, 2'b11);

        // Reset while PENDING discards the shadow and restores defaults.
        cfg_valid = 1'b1; cfg_sel = 1'b0; cfg_color = 3'b001; cfg_blink = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        check("rst_pend_ready", 32'(cfg_ready), 0);
        reset = 1'b1; cyc(); reset = 1'b0;
        check("after_rst_ready", 32'(cfg_ready), 1);
        txt_on = 2'b01; cyc(); pix("def_color0", 3'b010, 2'b01);
        txt_on = 2'b10; cyc(); pix("def_color1", 3'b100, 2'b10);
        txt_on = 2'b01;
        frame_tick(); cyc();
        check("no_commit_ready", 32'(cfg_ready), 1);
        pix("no_commit_rgb", 3'b010, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
